// File: rtl/kinase_protocol_sequencer_if.sv
// Host-side bundle for the kinase protocol sequencer: step-table port, run control, status and
// the valve/pump pad drives.
interface kinase_protocol_sequencer_if #(
    parameter int unsigned PROG_DEPTH = 16
);
    localparam int unsigned AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [43:0]   cfg_data;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [AW-1:0] step_idx;
    logic [12:0]   pad_ctrl_a;
    logic [3:0]    pad_ctrl_s;
    logic [2:0]    pad_pump_a;
    logic [1:0]    pad_pump_b;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, abort,
        input  busy, done, cfg_err, step_idx, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, abort,
        output busy, done, cfg_err, step_idx, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b
    );
endinterface

// File: rtl/kinase_protocol_sequencer.sv
// Step-table sequencer: per step applies a valve pattern, settles, runs pump A or B for a number
// of strokes, dwells, then advances until a last-flagged step or the end of the table.
module kinase_protocol_sequencer #(
    parameter int unsigned PROG_DEPTH    = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PUMP_DIV      = 8
) (
    input logic                         clk,
    input logic                         rst,
    kinase_protocol_sequencer_if.slave  host_io
);
    localparam int unsigned AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int unsigned DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [15:0]   SettleLast = 16'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DivLast    = DW'(PUMP_DIV - 1);
    localparam logic [AW-1:0] StepLast   = AW'(PROG_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StPump, StDwell} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic [43:0]   cur_q, cur_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    stroke_q, stroke_d;
    logic [2:0]    phase_q, phase_d;
    logic [DW-1:0] div_q, div_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [43:0]   mem_q [PROG_DEPTH];

    // Fields of the step currently being executed
    logic          cur_last;
    logic [15:0]   cur_dwell;
    logic [7:0]    cur_strokes;
    logic [1:0]    cur_sel;
    logic          pump_en;
    logic [2:0]    phase_last;
    logic [AW-1:0] step_nxt;

    assign cur_last    = cur_q[43];
    assign cur_dwell   = cur_q[42:27];
    assign cur_strokes = cur_q[26:19];
    assign cur_sel     = cur_q[18:17];
    assign pump_en     = (cur_strokes != 8'd0) && ((cur_sel == 2'b01) || (cur_sel == 2'b10));
    assign phase_last  = (cur_sel == 2'b01) ? 3'd5 : 3'd1;
    assign step_nxt    = step_q + AW'(1);

    // Table is deliberately left unreset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (host_io.cfg_we && (state_q == StIdle)) begin
            mem_q[host_io.cfg_addr] <= host_io.cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            stroke_q <= '0;
            phase_q  <= '0;
            div_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            stroke_q <= stroke_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        logic settle_end;
        logic pump_end;
        logic go_dwell;
        logic step_end;

        state_d    = state_q;
        step_d     = step_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        stroke_d   = stroke_q;
        phase_d    = phase_q;
        div_d      = div_q;
        done_d     = 1'b0;
        err_d      = err_q;
        settle_end = 1'b0;
        pump_end   = 1'b0;
        go_dwell   = 1'b0;
        step_end   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host_io.start && !host_io.abort) begin
                    state_d = StSettle;
                    step_d  = '0;
                    cur_d   = mem_q[0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) settle_end = 1'b1;
                else                     cnt_d = cnt_q + 16'd1;
            end
            StPump: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (phase_q == phase_last) begin
                        phase_d = '0;
                        if (stroke_q == cur_strokes - 8'd1) pump_end = 1'b1;
                        else                                stroke_d = stroke_q + 8'd1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            StDwell: begin
                if (cnt_q == cur_dwell - 16'd1) step_end = 1'b1;
                else                            cnt_d = cnt_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase

        if (settle_end) begin
            if (pump_en) begin
                state_d  = StPump;
                div_d    = '0;
                phase_d  = '0;
                stroke_d = '0;
            end else begin
                go_dwell = 1'b1;
            end
        end
        if (pump_end) go_dwell = 1'b1;

        if (go_dwell) begin
            if (cur_dwell != 16'd0) begin
                state_d = StDwell;
                cnt_d   = '0;
            end else begin
                step_end = 1'b1;
            end
        end

        if (step_end) begin
            if (cur_last || (step_q == StepLast)) begin
                state_d = StIdle;
                step_d  = '0;
                cur_d   = '0;
                done_d  = 1'b1;
            end else begin
                state_d = StSettle;
                step_d  = step_nxt;
                cur_d   = mem_q[step_nxt];
                cnt_d   = '0;
            end
        end

        if (host_io.cfg_we && (state_q != StIdle)) err_d = 1'b1;

        if (host_io.abort) begin
            state_d = StIdle;
            step_d  = '0;
            cur_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        host_io.busy       = (state_q != StIdle);
        host_io.done       = done_q;
        host_io.cfg_err    = err_q;
        host_io.step_idx   = step_q;
        host_io.pad_ctrl_a = '0;
        host_io.pad_ctrl_s = '0;
        host_io.pad_pump_a = '0;
        host_io.pad_pump_b = '0;
        if (state_q != StIdle) begin
            host_io.pad_ctrl_a = cur_q[12:0];
            host_io.pad_ctrl_s = cur_q[16:13];
        end
        if (state_q == StPump) begin
            if (cur_sel == 2'b01) begin
                case (phase_q)
                    3'd0:    host_io.pad_pump_a = 3'b100;
                    3'd1:    host_io.pad_pump_a = 3'b110;
                    3'd2:    host_io.pad_pump_a = 3'b010;
                    3'd3:    host_io.pad_pump_a = 3'b011;
                    3'd4:    host_io.pad_pump_a = 3'b001;
                    3'd5:    host_io.pad_pump_a = 3'b101;
                    default: host_io.pad_pump_a = 3'b000;
                endcase
            end else if (cur_sel == 2'b10) begin
                host_io.pad_pump_b = phase_q[0] ? 2'b01 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_kinase_protocol_sequencer.sv
// Bench for kinase_protocol_sequencer: two instances (default and small/fast) checked cycle by
// cycle against a trace built from the step-table rules.
module tb_kinase_protocol_sequencer;
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [7:0]  step;
        logic [12:0] a;
        logic [3:0]  s;
        logic [2:0]  pa;
        logic [1:0]  pb;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kinase_protocol_sequencer_if #(.PROG_DEPTH(16)) if0 ();
    kinase_protocol_sequencer_if #(.PROG_DEPTH(4))  if1 ();

    kinase_protocol_sequencer #(.PROG_DEPTH(16), .SETTLE_CYCLES(4), .PUMP_DIV(8)) dut0 (
        .clk(clk), .rst(rst), .host_io(if0)
    );
    kinase_protocol_sequencer #(.PROG_DEPTH(4), .SETTLE_CYCLES(2), .PUMP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .host_io(if1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [43:0] mtbl [2][16];
    obs_t        exp_q [$];
    logic [2:0]  pa_pat [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [1:0]  pb_pat [2] = '{2'b10, 2'b01};

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 4;
    endfunction
    function automatic int settle_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction
    function automatic int div_of(input int d);
        return (d == 0) ? 8 : 1;
    endfunction

    function automatic logic [43:0] mk(input logic last, input logic [15:0] dwell,
                                       input logic [7:0] st, input logic [1:0] sel,
                                       input logic [3:0] vs, input logic [12:0] va);
        return {last, dwell, st, sel, vs, va};
    endfunction

    function automatic obs_t get_obs(input int d);
        obs_t o;
        if (d == 0) begin
            o = '{if0.busy, if0.done, if0.cfg_err, 8'(if0.step_idx), if0.pad_ctrl_a,
                  if0.pad_ctrl_s, if0.pad_pump_a, if0.pad_pump_b};
        end else begin
            o = '{if1.busy, if1.done, if1.cfg_err, 8'(if1.step_idx), if1.pad_ctrl_a,
                  if1.pad_ctrl_s, if1.pad_pump_a, if1.pad_pump_b};
        end
        return o;
    endfunction

    task automatic drive(input int d, input logic st, input logic ab, input logic we,
                         input logic [7:0] addr, input logic [43:0] data);
        if (d == 0) begin
            if0.start = st; if0.abort = ab; if0.cfg_we = we;
            if0.cfg_addr = addr[3:0]; if0.cfg_data = data;
        end else begin
            if1.start = st; if1.abort = ab; if1.cfg_we = we;
            if1.cfg_addr = addr[1:0]; if1.cfg_data = data;
        end
    endtask

    task automatic check(input string tag, input int idx, input obs_t o, input obs_t e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, o, e);
        end
    endtask

    task automatic write_word(input int d, input int addr, input logic [43:0] data);
        drive(d, 1'b0, 1'b0, 1'b1, 8'(addr), data);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        mtbl[d][addr] = data;
    endtask

    // Expected per-cycle outputs from the cycle after start acceptance through one idle cycle
    // past completion.
    task automatic build_exp(input int d);
        int          s;
        int          p;
        logic [43:0] w;
        obs_t        e;
        obs_t        e2;
        exp_q.delete();
        s = 0;
        while (1) begin
            w = mtbl[d][s];
            e = '0;
            e.busy = 1'b1;
            e.step = 8'(s);
            e.a    = w[12:0];
            e.s    = w[16:13];
            for (int c = 0; c < settle_of(d); c++) exp_q.push_back(e);
            p = (w[18:17] == 2'd1) ? 6 : (w[18:17] == 2'd2) ? 2 : 0;
            for (int k = 0; k < int'(w[26:19]); k++) begin
                for (int ph = 0; ph < p; ph++) begin
                    e2 = e;
                    if (p == 6) e2.pa = pa_pat[ph];
                    else        e2.pb = pb_pat[ph];
                    for (int c = 0; c < div_of(d); c++) exp_q.push_back(e2);
                end
            end
            for (int c = 0; c < int'(w[42:27]); c++) exp_q.push_back(e);
            if (w[43] || (s == depth_of(d) - 1)) break;
            s++;
        end
        e = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
        e.done = 1'b0;
        exp_q.push_back(e);
    endtask

    // Start a run and compare each cycle; optional start-while-busy, cfg_we-while-busy and abort
    // injections at given trace indices (-1 = none).
    task automatic run_check(input int d, input string tag, input int sb_at, input int we_at,
                             input int ab_at);
        obs_t o;
        obs_t e;
        logic aborted;
        build_exp(d);
        drive(d, 1'b1, 1'b0, 1'b0, 8'd0, 44'd0);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            aborted = (ab_at >= 0) && (i > ab_at);
            e = exp_q[i];
            if (aborted) e = '0;
            if ((we_at >= 0) && (i > we_at)) e.err = 1'b1;
            o = get_obs(d);
            if (!e.busy && !aborted) o.step = 8'd0;
            check(tag, i, o, e);
            if (aborted) break;
            drive(d, (i == sb_at), (i == ab_at), (i == we_at), 8'($urandom),
                  44'({$urandom(), $urandom()}));
            @(posedge clk); #1;
        end
        drive(d, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        if (ab_at >= 0) begin
            e = '0;
            e.err = (we_at >= 0);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check({tag, "_post"}, i, get_obs(d), e);
            end
        end
    endtask

    initial begin
        obs_t z;
        obs_t o;
        z = '0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset0", 0, get_obs(0), z);
        check("reset1", 0, get_obs(1), z);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single step, pump A, default timing
        write_word(0, 0, mk(1'b1, 16'd3, 8'd2, 2'd1, 4'hA, 13'h1234));
        run_check(0, "pumpA", -1, -1, -1);

        // Two steps: pump B then no pump, PUMP_DIV=1
        write_word(1, 0, mk(1'b0, 16'd0, 8'd3, 2'd2, 4'h3, 13'h0F0F));
        write_word(1, 1, mk(1'b1, 16'd2, 8'd5, 2'd0, 4'hC, 13'h1555));
        run_check(1, "pumpB", -1, -1, -1);

        // Table wrap without last bits, write during run, then rerun with unchanged table
        for (int k = 0; k < 4; k++) begin
            write_word(1, k, mk(1'b0, 16'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
                                2'($urandom_range(0, 3)), 4'($urandom), 13'($urandom)));
        end
        run_check(1, "wrap_we", -1, 4, -1);
        run_check(1, "wrap_reread", -1, -1, -1);

        // Abort mid-pump, then clean restart
        write_word(0, 0, mk(1'b0, 16'd2, 8'd3, 2'd1, 4'h6, 13'h0AAA));
        write_word(0, 1, mk(1'b1, 16'd1, 8'd1, 2'd2, 4'h9, 13'h1001));
        run_check(0, "abort", -1, -1, 24);
        run_check(0, "restart", -1, -1, -1);

        // Start while busy must not restart
        run_check(0, "start_busy", 7, -1, -1);

        // Start and abort together in idle
        drive(0, 1'b1, 1'b1, 1'b0, 8'd0, 44'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        for (int i = 0; i < 3; i++) begin
            check("start_abort", i, get_obs(0), z);
            @(posedge clk); #1;
        end

        // Random programs on both instances
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) begin
                write_word(0, k, mk(($urandom_range(0, 3) == 0), 16'($urandom_range(0, 6)),
                                    8'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                                    4'($urandom), 13'($urandom)));
            end
            run_check(0, "rand0", -1, -1, -1);
            for (int k = 0; k < 4; k++) begin
                write_word(1, k, mk(($urandom_range(0, 2) == 0), 16'($urandom_range(0, 6)),
                                    8'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                                    4'($urandom), 13'($urandom)));
            end
            run_check(1, "rand1", -1, -1, -1);
        end

        // Asynchronous reset in the middle of a dwell
        write_word(0, 0, mk(1'b1, 16'd20, 8'd0, 2'd0, 4'h5, 13'h0ABC));
        build_exp(0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'd0, 44'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 44'd0);
        for (int i = 0; i < 10; i++) begin
            check("pre_rst", i, get_obs(0), exp_q[i]);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        o = get_obs(0);
        check("async_rst", 0, o, z);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_rst", 0, get_obs(0), z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/kinase_protocol_sequencer.md
# kinase_protocol_sequencer

Programmable step sequencer driving the control-valve and pump pads of the kinase-activity chip (13 `ctrl_a` valves, 4 `ctrl_s` valves, 3-valve pump A, 2-valve pump B). A host loads a step table through a write port and then issues `start`. The block walks the table: it applies each valve pattern, waits for the valves to settle, runs the selected pump for N strokes, then dwells. It sits between the host/test controller and the `pad_ctrl_*`/`pad_pump_*` inputs of the pad-level chip wrapper; flush pads are not driven here.

## Interface

**Parameters**
- `PROG_DEPTH`, 16 — step-table entries; power of two, 2..256.
- `SETTLE_CYCLES`, 4 — valve settle time per step, ≥1.
- `PUMP_DIV`, 8 — cycles each pump phase is held, ≥1.

**Ports**
- `clk` input 1 — single clock; all state on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `cfg_we` input 1 — step-table write strobe.
- `cfg_addr` input log2(PROG_DEPTH) — step-table write address.
- `cfg_data` input 44 — step word. Fields:
  - [43] `last`
  - [42:27] `dwell` (16b)
  - [26:19] `strokes` (8b)
  - [18:17] `pump_sel` (00 none, 01 A, 10 B, 11 reserved = none)
  - [16:13] `valves_s`
  - [12:0] `valves_a`
- `start` input 1 — begin the program at step 0.
- `abort` input 1 — stop immediately.
- `busy` output 1 — program running.
- `done` output 1 — one-cycle pulse on normal completion.
- `cfg_err` output 1 — sticky; set when `cfg_we` arrives while `busy`; cleared by `start` accept or `rst`.
- `step_idx` output log2(PROG_DEPTH) — current step.
- `pad_ctrl_a` output 13 — valve drive; 1 = pressurized/closed.
- `pad_ctrl_s` output 4 — valve drive.
- `pad_pump_a` output 3 — pump A valve drive.
- `pad_pump_b` output 2 — pump B valve drive.

## Operation

- **States:** IDLE, SETTLE, PUMP, DWELL. Completion and abort both return to IDLE.
- **Table writes:** `cfg_we` in IDLE writes the table. `cfg_we` while `busy` is dropped and sets `cfg_err`.
- **Start:** `start` in IDLE is accepted. `start` while `busy` is ignored.
- **Step entry:**
  - Register `valves_a`/`valves_s` onto the pads and update `step_idx`.
  - Go to SETTLE for `SETTLE_CYCLES` cycles.
- **PUMP:**
  - Skipped when `strokes`=0 or `pump_sel` is none/reserved.
  - Pump A stroke is 6 phases: 100, 110, 010, 011, 001, 101.
  - Pump B stroke is 2 phases: 10, 01.
  - Each phase is held `PUMP_DIV` cycles.
  - The unselected pump's outputs are 00/000.
  - Pump outputs are 0 outside PUMP.
- **DWELL:** lasts `dwell` cycles; skipped when 0. Valves keep the step pattern throughout.
- **Step exit:**
  - If `last`=1 or `step_idx`=PROG_DEPTH-1: end of program.
  - Otherwise enter step `step_idx`+1.
- **End of program:**
  - Next cycle is IDLE: `busy`=0, `done`=1 for one cycle.
  - All pad outputs go to 0 (depressurized).
- **Abort:** `abort` (any state, priority over everything except `rst`) forces IDLE next cycle.
  - All pads 0, `busy`=0, `done` not pulsed, `step_idx`=0.
- **Simultaneous `start`+`abort` in IDLE:** abort wins; start not accepted.
- **Counters:** saturating-free; widths are sized to the fields (16b dwell, 8b strokes, 3b phase, ≥log2(PUMP_DIV) divider).

## Timing

- **Reset values:** all pad outputs 0, `busy`=0, `done`=0, `cfg_err`=0, `step_idx`=0. The table contents are not reset.
- **Start latency:** `start` sampled high in IDLE at edge T ⇒ from cycle T+1, `busy`=1, `step_idx`=0, and the step-0 valve pattern is on the pads.
- **Step timing:** a step entered at cycle E has:
  - SETTLE in cycles E .. E+S-1 (S=`SETTLE_CYCLES`).
  - First pump phase at E+S.
  - Dwell starting at E+S+strokes·P·`PUMP_DIV` (P=6 for A, 2 for B, 0 for none).
  - Next step entry at E+S+strokes·P·`PUMP_DIV`+`dwell`.
  - Valve patterns change only at step entry.
- **Completion:** the last step ends at cycle X ⇒ `done`=1 and `busy`=0 in cycle X, pads 0 in cycle X.
- **Abort latency:** `abort` at edge T ⇒ pads 0, `busy`=0 from cycle T+1.
- **Mid-run reset:** asynchronous reset mid-run clears outputs immediately, without waiting for a clock edge.

## Test plan

- **Single step, pump A:** step0 = {last=1, dwell=3, strokes=2, sel=A, s=4'hA, a=13'h1234}, defaults, start at T.
  - Pads = 13'h1234/4'hA in cycles T+1..T+4.
  - pump_a runs 100,110,010,011,001,101 ×2, 8 cycles per phase (T+5..T+100).
  - Dwell T+101..T+103.
  - `done` pulse at T+104.
- **Two steps, pump B then no pump, PUMP_DIV=1:**
  - step0 {strokes=3, sel=B, dwell=0} ⇒ pump_b shows 10,01,10,01,10,01.
  - step1 {strokes=5, sel=none, dwell=2, last=1} ⇒ pumps stay 0.
  - `step_idx` goes 0→1 exactly at the predicted entry cycle.
- **Table wrap with PROG_DEPTH=4:**
  - No `last` bits set ⇒ runs steps 0..3 then `done`.
  - `cfg_we` during run ⇒ `cfg_err`=1, and a re-read run shows the table unchanged.
- **Abort mid-PUMP:**
  - All pads 0 and `busy`=0 the next cycle, no `done`.
  - A subsequent `start` restarts at step 0 with full settle.
- **Corner cases:**
  - `start` while `busy` ⇒ no restart, timing unchanged.
  - `start`+`abort` in IDLE ⇒ stays IDLE.
  - `rst` asserted mid-DWELL ⇒ pads 0 before the next clock edge.
